// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the 8-to-3 handshake priority encoder.
package prio_enc_pkg;

    localparam int unsigned REQ_W  = 8;
    localparam int unsigned CODE_W = 3;

    // Reset value of the round-robin pointer: the first search starts at index 6.
    localparam logic [CODE_W-1:0] PTR_RST = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc8to3_comb.sv
// Combinational 8-to-3 priority encoder: index of the highest set bit plus an any-set flag.
module prio_enc8to3_comb
    import prio_enc_pkg::*;
(
    input  logic [REQ_W-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < REQ_W; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encoder8to3_hs.sv
// Priority encoder with a pending-request set and a valid/ready handshake on the code.
// Optional macro PRIO_ENCODER_ROUND_ROBIN_EN: rotating priority starting below the last
// accepted index; without it, fixed priority with bit 7 highest.
module prio_encoder8to3_hs
    import prio_enc_pkg::*;
#(
    parameter int STICKY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQ_W-1:0]  req,
    input  logic              load,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic [REQ_W-1:0]  pending,
    output logic              none
);

    state_t              state;
    logic [REQ_W-1:0]    sel_vec;
    logic [CODE_W-1:0]   sel_idx;
    logic [CODE_W-1:0]   sel_code;
    logic                sel_any;
    logic                accept;
    logic [REQ_W-1:0]    clr_mask;
    logic [REQ_W-1:0]    pending_nxt;

    assign accept   = valid & ready;
    assign clr_mask = accept ? (REQ_W'(1) << code) : '0;
    assign none     = (pending == '0) && !valid;

`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
    logic [CODE_W-1:0]   last_accepted;
    logic [2*REQ_W-1:0]  dbl;

    // Rotate so index (last_accepted-1) lands on bit 7; the encoder result is rotated back.
    assign dbl      = {pending, pending} >> last_accepted;
    assign sel_vec  = dbl[REQ_W-1:0];
    assign sel_code = sel_idx + last_accepted;

    // Pointer advances only when a code is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_accepted <= PTR_RST;
        end else if (accept) begin
            last_accepted <= code;
        end
    end
`else
    assign sel_vec  = pending;
    assign sel_code = sel_idx;
`endif

    prio_enc8to3_comb u_enc (
        .vec (sel_vec),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Acceptance clears its bit first, then a load applies, so a same-edge set wins.
    always_comb begin
        pending_nxt = pending & ~clr_mask;
        if (load) begin
            if (STICKY != 0) begin
                pending_nxt = pending_nxt | req;
            end else begin
                pending_nxt = req;
            end
        end
    end

    // Pending request set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Offer FSM: select from pending in IDLE, hold code/valid in OFFER until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            code  <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        code  <= sel_code;
                        valid <= 1'b1;
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder8to3_hs.sv
// Self-checking bench for prio_encoder8to3_hs: one STICKY=1 and one STICKY=0 instance
// driven by the same stimulus, compared against a behavioural model of the request set.
module tb_prio_encoder8to3_hs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       load = 1'b0;
    logic       ready = 1'b0;

    logic [2:0] code_s, code_r;
    logic       valid_s, valid_r;
    logic [7:0] pend_s, pend_r;
    logic       none_s, none_r;

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = sticky instance, 1 = replace instance.
    logic [7:0] m_pend  [2];
    logic       m_valid [2];
    logic [2:0] m_code  [2];
    int         m_last  [2];

    always #5 clk = ~clk;

    prio_encoder8to3_hs #(.STICKY(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .req(req), .load(load), .code(code_s),
        .valid(valid_s), .ready(ready), .pending(pend_s), .none(none_s)
    );

    prio_encoder8to3_hs #(.STICKY(0)) u_dut_r (
        .clk(clk), .rst_n(rst_n), .req(req), .load(load), .code(code_r),
        .valid(valid_r), .ready(ready), .pending(pend_r), .none(none_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Which index is served next from set p, given the last accepted index.
    function automatic logic [2:0] pick(input logic [7:0] p, input int last);
`ifdef PRIO_ENCODER_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last - k + 16) % 8;
            if (p[i]) return 3'(i);
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (p[i]) return 3'(i);
        end
`endif
        return 3'd0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d]  = '0;
            m_valid[d] = 1'b0;
            m_code[d]  = '0;
            m_last[d]  = 7;
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [2:0] c;
            logic       v;
            logic [7:0] p;
            logic       n;
            c = (d == 0) ? code_s  : code_r;
            v = (d == 0) ? valid_s : valid_r;
            p = (d == 0) ? pend_s  : pend_r;
            n = (d == 0) ? none_s  : none_r;
            check($sformatf("valid[%0d]", d), 32'(v), 32'(m_valid[d]));
            check($sformatf("pending[%0d]", d), 32'(p), 32'(m_pend[d]));
            check($sformatf("none[%0d]", d), 32'(n), 32'((m_pend[d] == 0) && !m_valid[d]));
            if (m_valid[d]) check($sformatf("code[%0d]", d), 32'(c), 32'(m_code[d]));
        end
    endtask

    // One clock edge: advance the model with the pre-edge inputs, then compare.
    task automatic step();
        logic [7:0] r;
        logic       l, rd;
        r = req; l = load; rd = ready;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            logic [7:0] np;
            logic       acc;
            acc = m_valid[d] && rd;
            np  = m_pend[d];
            if (acc) np[m_code[d]] = 1'b0;
            if (l) np = (d == 0) ? (np | r) : r;
            if (!m_valid[d]) begin
                if (m_pend[d] != 0) begin
                    m_code[d]  = pick(m_pend[d], m_last[d]);
                    m_valid[d] = 1'b1;
                end
            end else if (acc) begin
                m_valid[d] = 1'b0;
                m_last[d]  = int'(m_code[d]);
            end
            m_pend[d] = np;
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(valid_s), 32'd0);
        check("rst_code", 32'(code_s), 32'd0);
        check("rst_pending", 32'(pend_s), 32'd0);
        check("rst_none", 32'(none_s), 32'd1);
        check("rst_valid_r", 32'(valid_r), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        do_reset();
        @(negedge clk);

        // Single request: valid two edges after the load edge, code 5.
        req = 8'b0010_0000; load = 1'b1; ready = 1'b1;
        step();
        load = 1'b0;
        check("single_not_yet", 32'(valid_s), 32'd0);
        step();
        check("single_valid", 32'(valid_s), 32'd1);
        check("single_code", 32'(code_s), 32'd5);
        step();
        check("single_cleared", 32'(pend_s), 32'd0);
        check("single_none", 32'(none_s), 32'd1);
        repeat (2) step();

        // Several requests drained one per two cycles.
        req = 8'b1000_0101; load = 1'b1; ready = 1'b1;
        step();
        load = 1'b0;
        repeat (8) step();

        // Backpressure: code held stable while ready is low.
        req = 8'b0000_1000; load = 1'b1; ready = 1'b0;
        step();
        load = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(valid_s), 32'd1);
            check("bp_code", 32'(code_s), 32'd3);
        end
        ready = 1'b1;
        step();
        check("bp_accepted", 32'(pend_s), 32'd0);
        repeat (3) step();

        // Same-edge accept and reload of the same bit: the bit survives and is offered again.
        req = 8'b0001_0000; load = 1'b1; ready = 1'b0;
        step();
        load = 1'b0;
        step();
        check("coll_code", 32'(code_s), 32'd4);
        ready = 1'b1; load = 1'b1;
        step();
        check("coll_pending", 32'(pend_s[4]), 32'd1);
        load = 1'b0; ready = 1'b0;
        step();
        check("coll_reoffer_valid", 32'(valid_s), 32'd1);
        check("coll_reoffer_code", 32'(code_s), 32'd4);
        ready = 1'b1;
        repeat (3) step();

        // Pending held at 1000_0001 by continuous reload.
        req = 8'b1000_0001; load = 1'b1; ready = 1'b1;
        repeat (10) step();
        load = 1'b0;
        repeat (6) step();

        // Reset in the middle of an offer clears everything without a clock.
        req = 8'b0100_0010; load = 1'b1; ready = 1'b0;
        step();
        load = 1'b0;
        step();
        check("pre_rst_valid", 32'(valid_s), 32'd1);
        #2;
        do_reset();
        @(negedge clk);
        req = 8'b0000_0100; load = 1'b1;
        step();
        load = 1'b0;
        check("post_rst_lat1", 32'(valid_s), 32'd0);
        step();
        check("post_rst_lat2", 32'(valid_s), 32'd1);
        check("post_rst_code", 32'(code_s), 32'd2);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            req   = 8'($urandom);
            load  = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 2) != 0);
            step();
            if ($urandom_range(0, 99) == 0) begin
                #2;
                do_reset();
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
